// File: rtl/vga_fb_pkg.sv
// ============================================================================
// Module   : vga_fb_pkg
// Purpose  : Shared constants and types for the frame-buffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_fb_pkg;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 12;
  localparam int FB_SIZE = 76800;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fsm_t;

endpackage

`default_nettype wire

// File: rtl/vga_fb_wfifo.sv
// ============================================================================
// Module   : vga_fb_wfifo
// Purpose  : Small synchronous FIFO holding pending {addr, data} pixel writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_wfifo
  import vga_fb_pkg::*;
#(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[PW-2:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[PW-2:0]];
  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (o_count == PW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares one frame-buffer RAM port between scanout, writes and clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_arbiter #(
  parameter int ADDR_W    = vga_fb_pkg::ADDR_W,
  parameter int DATA_W    = vga_fb_pkg::DATA_W,
  parameter int FB_SIZE   = vga_fb_pkg::FB_SIZE,
  parameter int WF_DEPTH  = 4,
  parameter int STALL_MAX = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sc_req,
  input  logic [ADDR_W-1:0] i_sc_addr,
  output logic [DATA_W-1:0] o_sc_data,
  output logic              o_sc_valid,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clr_start,
  input  logic [DATA_W-1:0] i_clr_color,
  output logic              o_clr_busy,
  output logic              o_wr_stall,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  import vga_fb_pkg::*;

  localparam int FW = ADDR_W + DATA_W;
  localparam int PW = $clog2(WF_DEPTH) + 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  fsm_t              r_state;
  fsm_t              w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_clr_color;
  logic              r_sc_valid;
  logic              r_clr_busy;
  logic              r_rdy_en;
  logic [SW-1:0]     r_stall_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [PW-1:0]     w_count;
  logic [FW-1:0]     w_head;
  logic              w_grant_clr;
  logic              w_clr_last;

  vga_fb_wfifo #(
    .WIDTH (FW),
    .DEPTH (WF_DEPTH)
  ) u_wfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({i_wr_addr, i_wr_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Scanout always wins; clear beats queued writes.
  assign w_grant_clr = !i_sc_req && (r_state == CLEAR);
  assign w_pop       = !i_sc_req && (r_state != CLEAR) && !w_empty;
  assign w_clr_last  = (r_clr_cnt == ADDR_W'(FB_SIZE - 1));
  assign o_wr_ready  = r_rdy_en && !w_full && (r_state == IDLE);
  assign w_push      = i_wr_valid && o_wr_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_clr_start) w_state_nxt = w_empty ? CLEAR : DRAIN;
      end
      DRAIN: begin
        if (w_empty || (w_pop && (w_count == PW'(1)))) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        if (w_grant_clr && w_clr_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (i_sc_req) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_sc_addr;
    end else if (w_grant_clr) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = r_clr_cnt;
      o_mem_wdata = r_clr_color;
    end else if (w_pop) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = w_head[FW-1:DATA_W];
      o_mem_wdata = w_head[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_clr_busy  <= 1'b0;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
      r_sc_valid  <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_busy <= (w_state_nxt != IDLE);
      r_sc_valid <= i_sc_req;
      r_rdy_en   <= 1'b1;

      if ((r_state == IDLE) && i_clr_start) begin
        r_clr_color <= i_clr_color;
        r_clr_cnt   <= '0;
      end else if (w_grant_clr) begin
        r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
      end

      // Starvation age of the FIFO head, saturating.
      if (w_empty || w_pop) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != SW'(STALL_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_sc_valid = r_sc_valid;
  assign o_sc_data  = i_mem_rdata;
  assign o_clr_busy = r_clr_busy;
  assign o_wr_stall = (r_stall_cnt == SW'(STALL_MAX));

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Directed self-checking bench for vga_fb_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_arbiter;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 12;
  localparam int FB_SIZE   = 1200;
  localparam int WF_DEPTH  = 4;
  localparam int STALL_MAX = 1023;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sc_req = 1'b0;
  logic [ADDR_W-1:0] sc_addr = '0;
  logic [DATA_W-1:0] sc_data;
  logic              sc_valid;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              clr_start = 1'b0;
  logic [DATA_W-1:0] clr_color = '0;
  logic              clr_busy;
  logic              wr_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0]        ram [0:(1<<ADDR_W)-1];
  logic [ADDR_W+DATA_W-1:0] wlog [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FB_SIZE   (FB_SIZE),
    .WF_DEPTH  (WF_DEPTH),
    .STALL_MAX (STALL_MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sc_req    (sc_req),
    .i_sc_addr   (sc_addr),
    .o_sc_data   (sc_data),
    .o_sc_valid  (sc_valid),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_clr_start (clr_start),
    .i_clr_color (clr_color),
    .o_clr_busy  (clr_busy),
    .o_wr_stall  (wr_stall),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Single-port RAM with 1-cycle read latency, plus a log of every write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] = mem_wdata;
        wlog.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return a[DATA_W-1:0] ^ 12'h5A5;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", wr_ready); end
    checks++; if (sc_valid !== 1'b0) begin errors++; $display("FAIL reset_sc_valid got %b exp 0", sc_valid); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got %b exp 0", clr_busy); end
    checks++; if (wr_stall !== 1'b0) begin errors++; $display("FAIL reset_wr_stall got %b exp 0", wr_stall); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_wr_ready got %b exp 1", wr_ready); end
  endtask

  task automatic test_scanout();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sc_req = 1'b1; sc_addr = ADDR_W'(k);
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ADDR_W'(k)) begin
        errors++; $display("FAIL scan_mem_k%0d got en=%b we=%b addr=%0d exp en=1 we=0 addr=%0d", k, mem_en, mem_we, mem_addr, k);
      end
      if (k > 0) begin
        checks++;
        if (sc_valid !== 1'b1 || sc_data !== DATA_W'((k-1)*3)) begin
          errors++; $display("FAIL scan_data_k%0d got v=%b d=%0d exp v=1 d=%0d", k, sc_valid, sc_data, (k-1)*3);
        end
      end
    end
    @(negedge clk);
    sc_req = 1'b0;
    #1;
    checks++; if (sc_valid !== 1'b1 || sc_data !== 12'd21) begin errors++; $display("FAIL scan_last got v=%b d=%0d exp v=1 d=21", sc_valid, sc_data); end
    @(negedge clk);
    #1;
    checks++; if (sc_valid !== 1'b0) begin errors++; $display("FAIL scan_valid_drop got %b exp 0", sc_valid); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 12'hF00;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_accept got %b exp 1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 17'd100 || mem_wdata !== 12'hF00) begin
      errors++; $display("FAIL wr_mem got we=%b addr=%0d data=%h exp we=1 addr=100 data=f00", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_pulse_end got %b exp 0", mem_we); end
    sc_req = 1'b1; sc_addr = 17'd100;
    @(negedge clk);
    sc_req = 1'b0;
    #1;
    checks++; if (sc_valid !== 1'b1 || sc_data !== 12'hF00) begin errors++; $display("FAIL wr_readback got v=%b d=%h exp v=1 d=f00", sc_valid, sc_data); end
  endtask

  task automatic test_fifo_full();
    @(negedge clk);
    sc_req = 1'b1; sc_addr = 17'd5;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      wr_valid = 1'b1; wr_addr = ADDR_W'(200 + i); wr_data = DATA_W'(12'h100 + i);
      #1;
      checks++; if (wr_ready !== (i < 4)) begin errors++; $display("FAIL full_ready_i%0d got %b exp %b", i, wr_ready, i < 4); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL full_no_we_i%0d got %b exp 0", i, mem_we); end
    end
    @(negedge clk);
    wr_valid = 1'b0; sc_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(200 + j) || mem_wdata !== DATA_W'(12'h100 + j)) begin
        errors++; $display("FAIL drain_j%0d got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h", j, mem_we, mem_addr, mem_wdata, 200 + j, 12'h100 + j);
      end
      checks++; if (wr_ready !== (j != 0)) begin errors++; $display("FAIL drain_ready_j%0d got %b exp %b", j, wr_ready, j != 0); end
    end
    @(negedge clk);
    #1;
    checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL drain_done got we=%b ready=%b exp we=0 ready=1", mem_we, wr_ready); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    sc_req = 1'b1; sc_addr = 17'd0;
    wr_valid = 1'b1; wr_addr = 17'd300; wr_data = 12'h123;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (STALL_MAX - 1) @(negedge clk);
    #1;
    checks++; if (wr_stall !== 1'b0) begin errors++; $display("FAIL stall_early got %b exp 0", wr_stall); end
    @(negedge clk);
    #1;
    checks++; if (wr_stall !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL stall_set got stall=%b we=%b exp stall=1 we=0", wr_stall, mem_we); end
    sc_req = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 17'd300 || wr_stall !== 1'b1) begin
      errors++; $display("FAIL stall_pop got we=%b addr=%0d stall=%b exp we=1 addr=300 stall=1", mem_we, mem_addr, wr_stall);
    end
    @(negedge clk);
    #1;
    checks++; if (wr_stall !== 1'b0) begin errors++; $display("FAIL stall_clear got %b exp 0", wr_stall); end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    logic              prev_req;
    logic [ADDR_W-1:0] prev_addr;
    wlog.delete();
    @(negedge clk);
    sc_req = 1'b1; sc_addr = 17'd0;
    wr_valid = 1'b1; wr_addr = 17'd1500; wr_data = 12'h0E1;
    @(negedge clk);
    wr_addr = 17'd1501; wr_data = 12'h0E2;
    @(negedge clk);
    wr_valid = 1'b0; clr_start = 1'b1; clr_color = 12'h0A5;
    @(negedge clk);
    clr_start = 1'b0; clr_color = '0; sc_req = 1'b0;
    #1;
    checks++;
    if (clr_busy !== 1'b1 || wr_ready !== 1'b0 || wlog.size() != 0) begin
      errors++; $display("FAIL clr_begin got busy=%b ready=%b writes=%0d exp busy=1 ready=0 writes=0", clr_busy, wr_ready, wlog.size());
    end
    n = 0; prev_req = 1'b0; prev_addr = '0;
    while (n < 4 * FB_SIZE) begin
      @(negedge clk);
      sc_req = n[0]; sc_addr = ADDR_W'(2000 + n % 16);
      #1;
      if (prev_req) begin
        checks++;
        if (sc_valid !== 1'b1 || sc_data !== init_val(prev_addr)) begin
          errors++; $display("FAIL clr_scan_n%0d got v=%b d=%h exp v=1 d=%h", n, sc_valid, sc_data, init_val(prev_addr));
        end
      end
      if (sc_req) begin
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clr_we_during_scan_n%0d got %b exp 0", n, mem_we); end
      end
      prev_req = sc_req; prev_addr = sc_addr;
      if (!clr_busy) break;
      n++;
    end
    @(negedge clk);
    sc_req = 1'b0;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_timeout got busy=%b exp 0", clr_busy); end
    checks++; if (wlog.size() != FB_SIZE + 2) begin errors++; $display("FAIL clr_write_count got %0d exp %0d", wlog.size(), FB_SIZE + 2); end
    checks++;
    if (wlog.size() < 2 || wlog[0] !== {17'd1500, 12'h0E1} || wlog[1] !== {17'd1501, 12'h0E2}) begin
      errors++; $display("FAIL clr_drain_first got n=%0d exp writes to 1500/0e1 then 1501/0e2 first", wlog.size());
    end
    bad = 0;
    for (int i = 0; i < FB_SIZE && i + 2 < wlog.size(); i++) begin
      if (wlog[i+2] !== {ADDR_W'(i), 12'h0A5}) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_sequence got %0d bad entries exp 0", bad); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_ready_after got %b exp 1", wr_ready); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    wlog.delete();
    @(negedge clk);
    sc_req = 1'b0; clr_start = 1'b1; clr_color = 12'h3C3;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (wlog.size() < 1000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 17'd1000 || wlog.size() != 1000) begin
      errors++; $display("FAIL rstclr_at1000 got we=%b addr=%0d writes=%0d exp we=1 addr=1000 writes=1000", mem_we, mem_addr, wlog.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || clr_busy !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL rstclr_in_reset got we=%b busy=%b ready=%b exp 0 0 0", mem_we, clr_busy, wr_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin errors++; $display("FAIL rstclr_release got ready=%b busy=%b exp 1 0", wr_ready, clr_busy); end
    repeat (5) @(negedge clk);
    checks++; if (wlog.size() != 1000) begin errors++; $display("FAIL rstclr_no_more_writes got %0d exp 1000", wlog.size()); end
    checks++;
    if (ram[999] !== 12'h3C3 || ram[1000] !== 12'h0A5 || ram[FB_SIZE-1] !== 12'h0A5) begin
      errors++; $display("FAIL rstclr_contents got %h %h %h exp 3c3 0a5 0a5", ram[999], ram[1000], ram[FB_SIZE-1]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = init_val(ADDR_W'(a));
    for (int a = 0; a < 8; a++) ram[a] = DATA_W'(a * 3);
    test_reset();
    test_scanout();
    test_write_read();
    test_fifo_full();
    test_stall();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Arbitrates a single-port frame-buffer RAM between three users: the VGA scanout pixel fetch, a buffered pixel-write port, and a built-in clear-screen engine.
- Scanout has absolute priority, so it never loses a pixel.
- Writes and clears use the free cycles, mainly blanking intervals.
- Sits between the VGA timing/colour path (Hsynq/Vsynq/blank/RGB 4:4:4) and the frame-buffer RAM in top.

Parameters:
ADDR_W, 17, frame-buffer address width
DATA_W, 12, pixel width (R,G,B 4 bits each)
FB_SIZE, 76800, number of pixels cleared (320x240)
WF_DEPTH, 4, write FIFO depth (power of 2)
STALL_MAX, 1023, cycles a pending write may wait before wr_stall asserts

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
sc_req  in  1  scanout read request, one per pixel
sc_addr  in  ADDR_W  scanout pixel address
sc_data  out  DATA_W  scanout pixel data
sc_valid  out  1  sc_data valid
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid&&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write pixel
clr_start  in  1  pulse: clear whole buffer
clr_color  in  DATA_W  clear colour, sampled with clr_start
clr_busy  out  1  drain/clear in progress
wr_stall  out  1  FIFO head starved >= STALL_MAX cycles
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency

Behaviour:
Reset (reset=0, async):
- FIFO emptied; FSM goes to IDLE; clear counter = 0.
- All registered outputs go to 0: sc_valid, clr_busy, wr_stall.
- wr_ready is 0 while reset is asserted and 1 on the first cycle after release.
- A reset during CLEAR aborts the clear with no further writes.

Arbitration (combinational each cycle):
- Priority order: sc_req, then CLEAR write, then FIFO head write.
- sc_req: mem_en=1, mem_we=0, mem_addr=sc_addr.
- CLEAR: mem_we=1, mem_addr=clr_cnt, mem_wdata=latched colour.
- FIFO head write (state IDLE or DRAIN): mem_we=1, the FIFO pops.
- Otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.

Scanout timing:
- sc_valid is a register: sc_valid(t+1) = sc_req(t).
- sc_data = mem_rdata, passed through.
- Fixed latency of 1 cycle; back-to-back requests are allowed every cycle.

Write FIFO:
- WF_DEPTH entries of {addr, data}.
- wr_ready = !full && state==IDLE.
- Simultaneous push and pop leaves the count unchanged.
- A push when full is impossible, because wr_ready is low.
- Writes retire in order.

FSM:
- IDLE: clr_start moves to DRAIN if the FIFO is non-empty, else straight to CLEAR. clr_color is latched and clr_cnt=0 in both cases.
- DRAIN: the FIFO empties via free cycles; go to CLEAR on the cycle the last entry pops.
- CLEAR: clr_cnt increments only on cycles where the clear write is granted. On the granted write with clr_cnt==FB_SIZE-1, go to IDLE.
- clr_busy = (state != IDLE), registered with the state.
- clr_start is ignored outside IDLE.

wr_stall:
- A counter increments on each cycle the FIFO is non-empty and the head is not popped.
- It resets to 0 on a pop or when the FIFO is empty, and saturates at STALL_MAX.
- wr_stall = (counter == STALL_MAX).

Widths:
- clr_cnt is ADDR_W wide and must hold FB_SIZE-1.
- FIFO pointers are log2(WF_DEPTH)+1 bits with wrap.

Decomposition:
- Package vga_fb_pkg: ADDR_W, DATA_W, FB_SIZE constants; the pixel_t typedef (logic [11:0]); the fsm_t enum {IDLE, DRAIN, CLEAR}.
- One sub-module: vga_fb_wfifo, a synchronous FIFO with push/pop/full/empty and the same asynchronous active-low reset.

Test Plan:
1. Reset, then sc_req held high for 8 cycles, addr 0..7, RAM preloaded with addr*3 -> sc_valid high cycles 1..8, sc_data 0,3,...,21; mem_we never 1.
2. With sc_req=0, write addr 100 data 12'hF00, then read addr 100 -> mem_we pulse 1 cycle after acceptance; read returns 12'hF00 one cycle after sc_req.
3. sc_req held high while 5 writes are offered -> 4 accepted; wr_ready=0 on the 5th; no mem_we while sc_req=1. Drop sc_req -> 4 writes in order on consecutive cycles; wr_ready returns to 1.
4. sc_req held STALL_MAX cycles with 1 pending write -> wr_stall=1 after exactly STALL_MAX cycles; clears the cycle after the write pops.
5. clr_start with clr_color=12'h0A5, 2 pending writes, sc_req toggling 50% -> clr_busy rises; the 2 writes retire first; every address 0..76799 is written 12'h0A5 exactly once; clr_busy falls after the last write; scanout reads stay correct throughout.
6. Assert reset at clr_cnt=1000 -> no mem_we after reset; clr_busy=0, wr_ready=1 after release; addresses >=1000 keep their old contents.
